// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between decode, seq_alu and writeback
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             branch;
    logic             busy;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, branch, busy
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, branch, busy
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: single-cycle ops plus iterative MUL/DIVU/REMU
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_LT   = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_GT   = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;
    localparam logic [3:0] OP_LTS  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             branch_q, branch_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_br;
    logic             is_iter;

    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        sc_res  = bus.a + bus.b;
        sc_br   = 1'b0;
        is_iter = 1'b0;
        case (bus.alu_op)
            OP_SUB:  sc_res = bus.a - bus.b;
            OP_SLL:  sc_res = bus.a << shamt;
            OP_SRL:  sc_res = bus.a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_EQ:   sc_br  = (bus.a == bus.b);
            OP_GT:   sc_br  = (bus.a > bus.b);
            OP_LT:   sc_br  = (bus.a < bus.b);
            OP_LTS:  sc_br  = ($signed(bus.a) < $signed(bus.b));
            OP_MUL, OP_DIVU, OP_REMU: is_iter = 1'b1;
            default: sc_res = bus.a + bus.b;
        endcase
        if (bus.alu_op == OP_EQ || bus.alu_op == OP_GT ||
            bus.alu_op == OP_LT || bus.alu_op == OP_LTS) begin
            sc_res = {{(WIDTH-1){1'b0}}, sc_br};
        end
    end

    // MUL: acc accumulates a_q (shifted left) for each set bit of b_q (shifted right).
    // DIV/REM: a_q shifts the dividend out at the top and the quotient in at the bottom;
    // acc holds the partial remainder. A zero divisor naturally yields all-ones / a.
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        mul_acc  = acc_q + (b_q[0] ? a_q : '0);
        rem_sh   = {acc_q, a_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        rem_ge   = ~rem_diff[WIDTH];
        rem_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {a_q[WIDTH-2:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        branch_d = branch_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d = bus.alu_op;
                    a_d  = bus.a;
                    b_d  = bus.b;
                    if (is_iter) begin
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_BUSY;
                    end else begin
                        result_d = sc_res;
                        branch_d = sc_br;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = rem_next;
                    a_d   = quo_next;
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    branch_d = 1'b0;
                    if (op_q == OP_MUL)
                        result_d = mul_acc;
                    else if (op_q == OP_DIVU)
                        result_d = quo_next;
                    else
                        result_d = rem_next;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.branch    = branch_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed self-checking bench for seq_alu
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();
    seq_alu #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_rdy = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         br;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t         expq[$];
    exp_t         cur;
    bit           have_cur = 0;
    int           vcnt = 0;
    int           last_vcnt = 0;
    int           txn_done = 0;
    logic [W-1:0] last_res = '0;
    logic         last_br = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference behaviour written directly from the op-code table.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic br);
        int sh;
        logic [W-1:0] ones;
        sh   = int'(b % W);
        ones = '1;
        br   = 1'b0;
        case (op)
            4'd1:  r = a - b;
            4'd2:  r = a << sh;
            4'd4:  r = a >> sh;
            4'd10: r = (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0);
            4'd3:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = a * b;
            4'd11: r = (b == 0) ? ones : a / b;
            4'd13: r = (b == 0) ? a : a % b;
            4'd12: br = (a == b);
            4'd9:  br = (a > b);
            4'd5:  br = (a < b);
            4'd14: br = (a[W-1] != b[W-1]) ? a[W-1] : (a < b);
            default: r = a + b;
        endcase
        if (op == 4'd12 || op == 4'd9 || op == 4'd5 || op == 4'd14)
            r = {{(W-1){1'b0}}, br};
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
        return (op == 4'd8 || op == 4'd11 || op == 4'd13);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            have_cur = 0;
        end else begin
            chk("busy_vs_in_ready", bus.busy, !bus.in_ready);
            if (bus.out_valid) begin
                if (!have_cur) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stale_result out_valid=1 result=%0h with no pending request", bus.result);
                    end else begin
                        cur = expq.pop_front();
                        have_cur = 1;
                        vcnt = 0;
                        chk("latency", cyc - cur.acc_cyc, cur.lat);
                    end
                end
                if (have_cur) begin
                    chk("result", bus.result, cur.res);
                    chk("branch", bus.branch, cur.br);
                    chk("in_ready_low_in_done", bus.in_ready, 0);
                    vcnt++;
                    last_res = bus.result;
                    last_br = bus.branch;
                end
            end else if (have_cur) begin
                have_cur = 0;
                last_vcnt = vcnt;
                txn_done++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_rdy) bus.out_ready = 1'($urandom % 2);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n;
        bus.a = a;
        bus.b = b;
        bus.alu_op = op;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=0 required=1");
            bus.in_valid = 1'b0;
            return;
        end
        model(op, a, b, e.res, e.br);
        e.acc_cyc = cyc + 1;
        e.lat = is_iter(op) ? W : 0;
        expq.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.alu_op = 4'($urandom);
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = txn_done;
        n = 0;
        while (txn_done == start && n < 200) begin
            tick();
            n++;
        end
        if (txn_done == start) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout txn_done=%0d required>%0d", txn_done, start);
        end
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_br);
        logic [W-1:0] r;
        logic br;
        model(op, a, b, r, br);
        chk({name, "_model_res"}, r, exp_r);
        chk({name, "_model_br"}, br, exp_br);
        issue(op, a, b);
        wait_done();
        chk({name, "_dut_res"}, last_res, exp_r);
        chk({name, "_dut_br"}, last_br, exp_br);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        logic [W-1:0] ra, rb;
        int n;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.alu_op = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_branch", bus.branch, 0);
        rst = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_busy", bus.busy, 0);

        directed("add", 4'd0, 32'd5, 32'd3, 32'd8, 1'b0);
        chk("add_valid_one_cycle", last_vcnt, 1);
        chk("add_in_ready_after", bus.in_ready, 1);
        directed("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        directed("undef_add", 4'd15, 32'd10, 32'd20, 32'd30, 1'b0);
        directed("mul", 4'd8, 32'd7, 32'd6, 32'd42, 1'b0);
        directed("mul_wrap", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
        directed("divu", 4'd11, 32'd100, 32'd7, 32'd14, 1'b0);
        directed("remu", 4'd13, 32'd100, 32'd7, 32'd2, 1'b0);
        directed("divu_zero", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
        directed("remu_zero", 4'd13, 32'd9, 32'd0, 32'd9, 1'b0);
        directed("lts", 4'd14, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
        directed("ltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        directed("gtu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
        directed("eq", 4'd12, 32'h1234, 32'h1234, 32'd1, 1'b1);
        directed("sra", 4'd10, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0);

        bus.out_ready = 1'b0;
        issue(4'd7, 32'hF0F0, 32'h0FF0);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.alu_op = 4'd0;
            bus.a = 32'(i);
            bus.b = 32'(i);
            tick();
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("bp_released_out_valid", bus.out_valid, 0);
        chk("bp_released_in_ready", bus.in_ready, 1);
        chk("bp_xor_res", last_res, 32'hFF00);

        bus.a = 32'd100;
        bus.b = 32'd7;
        bus.alu_op = 4'd11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("div_in_flight_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        repeat (40) tick();
        directed("add_after_rst", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0);

        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            case ($urandom % 4)
                0: begin ra = $urandom; rb = 32'($urandom % 8); end
                1: begin ra = $urandom % 1000; rb = $urandom % 40; end
                2: begin ra = $urandom; rb = (($urandom % 2) == 0) ? ra : 32'd0; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            issue(op, ra, rb);
        end
        rand_rdy = 0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || have_cur) && n < 200) begin
            tick();
            n++;
        end
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor of the combinational datapath ALU.
- Adds iterative multiply, divide and remainder, plus XOR, arithmetic shift right and signed less-than.
- Single-cycle ops have 1-cycle latency. MUL, DIVU and REMU take WIDTH iterations.
- Sits between the decode stage and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand/result width; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from b[SHW-1:0]; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  4  operation code
- out_valid  output  1  result/branch valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- branch  output  1  registered compare outcome
- busy  output  1  high in BUSY or DONE

Behaviour:
- Op codes:
  - 0000 ADD; 0001 SUB; 0010 SLL; 0100 SRL; 1010 SRA; 0011 AND; 0110 OR; 0111 XOR
  - 1000 MUL: low WIDTH bits of the product, unsigned
  - 1011 DIVU; 1101 REMU
  - 1100 EQ; 1001 GT unsigned; 0101 LT unsigned; 1110 LTS signed
  - any other code executes ADD.
- Shifts use b[SHW-1:0] only.
- All arithmetic is modulo 2^WIDTH with no overflow flag.
- Compare ops: branch = outcome; result = outcome zero-extended.
- All non-compare ops: branch = 0.
- Divide by zero: DIVU result = all ones; REMU result = a. No exception.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. An accept (in_valid & in_ready at a clk edge) latches a, b and alu_op.
    - Single-cycle op: result computed at that edge; next state DONE.
    - MUL/DIVU/REMU: next state BUSY; iteration counter loaded with WIDTH.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; counter decrements.
    - Leaves for DONE on the edge where the counter reaches 0.
    - After the accept edge, the WIDTH-th BUSY edge enters DONE.
  - DONE: out_valid=1; result and branch stable.
    - On out_ready=1 at an edge: next state IDLE, out_valid falls.
    - Otherwise hold indefinitely; result and branch must not change.
- Latency, with accept at edge N:
  - single-cycle op: out_valid high after edge N+1... precisely, out_valid is high from edge N (visible in the cycle after the accept).
  - iterative op: out_valid high from edge N+WIDTH.
- No pipelining: a new request is accepted only in IDLE, so the earliest next accept is the edge after the DONE→IDLE handoff.
- in_valid while not in IDLE is ignored. Requesters must hold in_valid and operands until in_ready is seen.
- Operands are sampled only at accept; changes to a/b/alu_op during BUSY/DONE have no effect.
- busy = (state != IDLE); in_ready = (state == IDLE).
- Reset, taking priority over all else including mid-BUSY:
  - state = IDLE; out_valid = 0; result = 0; branch = 0; counter = 0; internal operand/accumulator registers = 0.
  - In-flight operation discarded; no result emitted.
  - in_ready = 1 in the first cycle after reset is deasserted.

Test Plan:
- ADD a=5, b=3, out_ready=1 -> result=8, branch=0, out_valid for exactly one cycle, visible the cycle after the accept edge; in_ready high again the following cycle.
- MUL a=7, b=6, WIDTH=32 -> result=42 with out_valid first high 32 edges after accept; a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE.
- DIVU 100/7 -> result=14; REMU 100/7 -> 2; DIVU a=9, b=0 -> 0xFFFFFFFF; REMU a=9, b=0 -> 9.
- Compares with a=0xFFFFFFFF, b=1:
  - LTS -> branch=1, result=1
  - LT -> branch=0
  - GT -> branch=1
  - EQ a=b=0x1234 -> branch=1
  - SRA of 0x80000000 by b=0x21 (shift 1) -> 0xC0000000.
- Backpressure: hold out_ready=0 for 10 cycles after an XOR (0xF0F0 ^ 0x0FF0 = 0xFF00) -> out_valid, result and branch stable; in_ready=0; in_valid pulses ignored; completes on the first out_ready=1 edge.
- Assert rst for one cycle during BUSY of a DIVU -> out_valid=0, result=0, in_ready=1 the cycle after deassertion; no stale result appears; a following ADD 1+1 -> 2.
